// File: rtl/wrr_arbiter_pkg.sv
// Shared definitions for the arbiter family: default sizes, FSM state type
// and the effective-weight clamp.
package arb_pkg;

   localparam int unsigned N_REQ_DEF    = 4;
   localparam int unsigned WEIGHT_W_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // A programmed weight of zero still earns one granted cycle.
   function automatic int unsigned eff_weight(input int unsigned w);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping to 0.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             found,
   output logic [ID_W-1:0]  idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         int unsigned w_cand;
         w_cand = (32'(ptr) + k) % N_REQ;
         if (!found && req[w_cand]) begin
            found = 1'b1;
            idx   = ID_W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: the winner keeps a registered one-hot grant
// for up to its effective weight in cycles, then priority rotates past it.
module wrr_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N_REQ    = N_REQ_DEF,
   parameter int unsigned WEIGHT_W = WEIGHT_W_DEF,
   parameter int unsigned ID_W     = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*WEIGHT_W-1:0] weight,
   output logic [N_REQ-1:0]          grant,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy
);

   state_t               r_state, w_state_nx;
   logic [N_REQ-1:0]     r_grant, w_grant_nx;
   logic [ID_W-1:0]      r_grant_id, w_id_nx;
   logic [ID_W-1:0]      r_ptr, w_ptr_nx;
   logic [WEIGHT_W-1:0]  r_credit, w_credit_nx;
   logic                 w_found;
   logic [ID_W-1:0]      w_idx;
   logic [ID_W-1:0]      w_idx_inc;
   logic [WEIGHT_W-1:0]  w_win_weight;
   logic                 w_release;

   // r_ptr always holds owner+1 while granted, so a single picker serves both
   // the IDLE search and the release search; a still-requesting owner is
   // reached last in the wrap and is only re-granted when alone.
   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .found (w_found),
      .idx   (w_idx)
   );

   always_comb begin
      w_win_weight = WEIGHT_W'(eff_weight(32'(weight[w_idx*WEIGHT_W +: WEIGHT_W])));
      w_idx_inc    = (32'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
      w_release    = (r_state == GRANT) && (!req[r_grant_id] || (r_credit == WEIGHT_W'(1)));
   end

   always_comb begin
      w_state_nx  = r_state;
      w_grant_nx  = r_grant;
      w_id_nx     = r_grant_id;
      w_ptr_nx    = r_ptr;
      w_credit_nx = r_credit;
      if ((r_state == IDLE) || w_release) begin
         if (w_found) begin
            w_state_nx  = GRANT;
            w_grant_nx  = N_REQ'(1) << w_idx;
            w_id_nx     = w_idx;
            w_ptr_nx    = w_idx_inc;
            w_credit_nx = w_win_weight;
         end else begin
            w_state_nx  = IDLE;
            w_grant_nx  = '0;
            w_id_nx     = '0;
            w_credit_nx = '0;
         end
      end else begin
         w_credit_nx = r_credit - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_ptr      <= '0;
         r_credit   <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_grant    <= w_grant_nx;
         r_grant_id <= w_id_nx;
         r_ptr      <= w_ptr_nx;
         r_credit   <= w_credit_nx;
      end
   end

   assign grant    = r_grant;
   assign grant_id = r_grant_id;
   assign busy     = |r_grant;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: expected grants are queued as each cycle's
// stimulus is driven and popped once the registered grant is visible.
module tb_wrr_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned WW = 4;
   localparam int unsigned IW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req = '1;
   logic [N*WW-1:0] weight = '0;
   logic [N-1:0]    grant;
   logic [IW-1:0]   grant_id;
   logic            busy;

   int          checks   = 0;
   int          failures = 0;
   int          step     = 0;
   string       phase    = "reset";
   logic [N-1:0] exp_q[$];

   wrr_arbiter #(
      .N_REQ    (N),
      .WEIGHT_W (WW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .weight   (weight),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] idx_of(input logic [N-1:0] g);
      for (int i = 0; i < N; i++)
         if (g[i]) return IW'(i);
      return '0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s/%s step %0d: observed=%0h expected=%0h", phase, tag, step, obs, exp);
      end
   endtask

   task automatic set_w(input logic [WW-1:0] w3, input logic [WW-1:0] w2,
                        input logic [WW-1:0] w1, input logic [WW-1:0] w0);
      weight = {w3, w2, w1, w0};
   endtask

   task automatic cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] exp);
      logic [N-1:0] e;
      rst = r;
      req = rq;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      step++;
      e = exp_q.pop_front();
      check("grant",    32'(grant),    32'(e));
      check("grant_id", 32'(grant_id), 32'(idx_of(e)));
      check("busy",     32'(busy),     32'(|e));
   endtask

   task automatic hold(input logic [N-1:0] rq, input int n, input logic [N-1:0] exp);
      for (int i = 0; i < n; i++) cycle(1'b0, rq, exp);
   endtask

   initial begin
      // Reset held with all requests up, then plain rotation at weight 1.
      set_w(4'd1, 4'd1, 4'd1, 4'd1);
      cycle(1'b1, 4'b1111, 4'b0000);
      cycle(1'b1, 4'b1111, 4'b0000);
      phase = "equal";
      cycle(1'b0, 4'b1111, 4'b0001);
      cycle(1'b0, 4'b1111, 4'b0010);
      cycle(1'b0, 4'b1111, 4'b0100);
      cycle(1'b0, 4'b1111, 4'b1000);
      cycle(1'b0, 4'b1111, 4'b0001);

      phase = "weighted";
      set_w(4'd0, 4'd2, 4'd1, 4'd3);
      cycle(1'b1, 4'b0000, 4'b0000);
      for (int r = 0; r < 2; r++) begin
         hold(4'b1111, 3, 4'b0001);
         hold(4'b1111, 1, 4'b0010);
         hold(4'b1111, 2, 4'b0100);
         hold(4'b1111, 1, 4'b1000);
      end

      phase = "single";
      set_w(4'd1, 4'd2, 4'd1, 4'd1);
      cycle(1'b1, 4'b0000, 4'b0000);
      hold(4'b0100, 6, 4'b0100);
      hold(4'b0000, 2, 4'b0000);

      phase = "early_drop";
      set_w(4'd1, 4'd1, 4'd1, 4'd4);
      cycle(1'b1, 4'b0000, 4'b0000);
      hold(4'b0011, 2, 4'b0001);
      hold(4'b0010, 4, 4'b0010);

      phase = "max_weight";
      set_w(4'd1, 4'd1, 4'd1, 4'd15);
      cycle(1'b1, 4'b0000, 4'b0000);
      hold(4'b0011, 3, 4'b0001);
      set_w(4'd1, 4'd1, 4'd1, 4'd1);
      hold(4'b0011, 12, 4'b0001);
      hold(4'b0011, 1, 4'b0010);
      hold(4'b0011, 1, 4'b0001);

      phase = "mid_reset";
      set_w(4'd1, 4'd1, 4'd5, 4'd1);
      cycle(1'b1, 4'b0000, 4'b0000);
      hold(4'b0010, 3, 4'b0010);
      cycle(1'b1, 4'b0011, 4'b0000);
      cycle(1'b0, 4'b0011, 4'b0001);
      hold(4'b0011, 5, 4'b0010);
      hold(4'b0011, 1, 4'b0001);
      hold(4'b0000, 1, 4'b0000);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
